// File: rtl/accel_pkg.sv
// Shared definitions for the Wishbone cipher-accelerator bridge: register
// offsets, STATUS/CTRL bit positions and the control FSM state encoding.
package accel_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_KEY    = 8'h10;
    localparam logic [7:0] OFF_DIN    = 8'h20;
    localparam logic [7:0] OFF_DOUT   = 8'h30;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_TIMEOUT = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    // A 16-byte bank is selected by the upper offset nibble; only word-aligned offsets map.
    function automatic logic in_bank(input logic [3:0] hi, input logic [1:0] lo,
                                     input logic [3:0] bank);
        return (hi == bank) && (lo == 2'b00);
    endfunction

endpackage

// File: rtl/accel_regfile.sv
// KEY/DIN/DOUT storage and the in-window read multiplexer for the bridge.
// KEY and DIN are byte-lane writable; DOUT is loaded only by the core.
module accel_regfile
    import accel_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [7:0]   offset,
    input  logic [31:0]  wdata,
    input  logic [3:0]   sel,
    input  logic         dout_load,
    input  logic [127:0] dout_data,
    input  logic [3:0]   status,
    output logic [127:0] key,
    output logic [127:0] din,
    output logic [31:0]  rdata
);

    logic [3:0][31:0] key_q;
    logic [3:0][31:0] din_q;
    logic [3:0][31:0] dout_q;
    logic [1:0]       idx;
    logic             hit_key;
    logic             hit_din;
    logic             hit_dout;

    assign idx      = offset[3:2];
    assign hit_key  = in_bank(offset[7:4], offset[1:0], OFF_KEY[7:4]);
    assign hit_din  = in_bank(offset[7:4], offset[1:0], OFF_DIN[7:4]);
    assign hit_dout = in_bank(offset[7:4], offset[1:0], OFF_DOUT[7:4]);

    // NOTE: these are flops, not a RAM, so they take the async reset; a real memory macro would not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            din_q  <= '0;
            dout_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            for (int b = 0; b < 4; b++) begin
                if (wr_en && hit_key && sel[b]) key_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                if (wr_en && hit_din && sel[b]) din_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
            if (dout_load) dout_q <= dout_data;
        end
    end

    assign key = key_q;
    assign din = din_q;

    always_comb begin
        // NOTE: default first so no path through this block leaves rdata unassigned (no latch).
        rdata = '0;
        if (offset == OFF_STATUS) rdata = {28'd0, status};
        else if (hit_key)         rdata = key_q[idx];
        else if (hit_din)         rdata = din_q[idx];
        else if (hit_dout)        rdata = dout_q[idx];
    end

endmodule

// File: rtl/wb_accel_bridge.sv
// Wishbone slave bridging a 256-byte register window to a 128-bit cipher core.
// Optional macro ACCEL_IRQ_EN drives irq_o from the done flag; otherwise irq_o is 0.
module wb_accel_bridge
    import accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_din_o,
    output logic         core_start_o,
    input  logic         core_ready_i,
    input  logic         core_done_i,
    input  logic [127:0] core_dout_i,
    output logic         irq_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             ack_q;
    logic [31:0]      dat_q;
    logic             done_q, err_q, to_q;
    logic [3:0]       status;
    logic [31:0]      rdata;
    logic [7:0]       offset;
    logic             busy, bus_req, bus_wr, ctrl_wr, data_wr;
    logic             start_req, clear_req, err_set;
    logic             dout_load, done_set, to_set;

    // ack_q gates a new request so two acks can never be adjacent.
    assign offset    = wbs_adr_i[7:0];
    assign bus_req   = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]) && !ack_q;
    assign bus_wr    = bus_req && wbs_we_i;
    assign busy      = (state != S_IDLE);
    assign ctrl_wr   = bus_wr && (offset == OFF_CTRL) && wbs_sel_i[0];
    assign start_req = ctrl_wr && wbs_dat_i[CTRL_START];
    assign clear_req = ctrl_wr && wbs_dat_i[CTRL_CLEAR];
    assign data_wr   = bus_wr && (in_bank(offset[7:4], offset[1:0], OFF_KEY[7:4]) ||
                                  in_bank(offset[7:4], offset[1:0], OFF_DIN[7:4]));
    assign err_set   = busy && (data_wr || start_req);

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = busy;
        status[ST_DONE]     = done_q;
        status[ST_ERR]      = err_q;
        status[ST_TIMEOUT]  = to_q;
    end

    accel_regfile u_regfile (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .wr_en     (bus_wr && !busy),
        .offset    (offset),
        .wdata     (wbs_dat_i),
        .sel       (wbs_sel_i),
        .dout_load (dout_load),
        .dout_data (core_dout_i),
        .status    (status),
        .key       (core_key_o),
        .din       (core_din_o),
        .rdata     (rdata)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        core_start_o = 1'b0;
        dout_load    = 1'b0;
        done_set     = 1'b0;
        to_set       = 1'b0;
        unique case (state)
            S_IDLE: if (start_req) state_nxt = S_REQ;
            S_REQ: begin
                core_start_o = 1'b1;
                if (core_ready_i) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_done_i) begin
                    dout_load = 1'b1;
                    done_set  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    to_set    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counts cycles spent in WAIT; restarts from zero on every entry.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)          wait_cnt <= '0;
        else if (state != S_WAIT) wait_cnt <= '0;
        else                     wait_cnt <= wait_cnt + 1'b1;
    end

    // A flag being set in the same cycle as CTRL.clear stays set.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            if (done_set)       done_q <= 1'b1;
            else if (clear_req) done_q <= 1'b0;
            if (err_set)        err_q  <= 1'b1;
            else if (clear_req) err_q  <= 1'b0;
            if (to_set)         to_q   <= 1'b1;
            else if (clear_req) to_q   <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= bus_req;
            dat_q <= (bus_req && !wbs_we_i) ? rdata : '0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

`ifdef ACCEL_IRQ_EN
    assign irq_o = done_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_accel_bridge.sv
// Directed bench for wb_accel_bridge (TIMEOUT_CYCLES=16); irq expectations follow ACCEL_IRQ_EN.
module tb_wb_accel_bridge;

    localparam logic [31:0]  BASE  = 32'h3000_0000;
    localparam logic [127:0] KEY_V = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] DIN_V = 128'h01234567_89ABCDEF_01234567_89ABCDEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]   sel = '0;
    logic [31:0]  adr = '0, wdat = '0;
    logic         ack;
    logic [31:0]  dat_o;
    logic [127:0] core_key, core_din;
    logic         core_start;
    logic         core_ready = 1'b0, core_done = 1'b0;
    logic [127:0] core_dout = '0;
    logic         irq;

    int total = 0;
    int bad   = 0;

    wb_accel_bridge #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_o),
        .core_key_o   (core_key),
        .core_din_o   (core_din),
        .core_start_o (core_start),
        .core_ready_i (core_ready),
        .core_done_i  (core_done),
        .core_dout_i  (core_dout),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer; waits at most 16 cycles for ack, returns at ack + 1 time unit.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                rd  = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        total++;
        assert (got === 1'b1) else begin
            bad++;
            $error("FAIL ack_timeout adr=%h observed=no_ack expected=ack", a);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, a, s, d, unused_rd);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 4'hF, 32'h0, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        exp_irq;
        int          n_ack;
`ifdef ACCEL_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif

        // Reset state
        #1 rst_n = 1'b0;
        #12;
        check1("rst_ack", ack, 1'b0);
        check32("rst_dat", dat_o, 32'h0);
        check1("rst_start", core_start, 1'b0);
        check1("rst_irq", irq, 1'b0);
        check128("rst_key", core_key, 128'h0);
        @(negedge clk) rst_n = 1'b1;

        wb_read(BASE + 32'h04, rd);
        check32("status_idle", rd, 32'h0);

        // Ack exactly one cycle after strobe, then a mandatory gap
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04; sel = 4'hF;
        @(posedge clk); #1;
        check1("ack_first", ack, 1'b1);
        @(posedge clk); #1;
        check1("ack_gap", ack, 1'b0);
        check32("dat_zero_outside_ack", dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0;

        // Out-of-window access never acked
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h100;
        n_ack = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
        end
        cyc = 1'b0; stb = 1'b0;
        check32("oow_noack", 32'(n_ack), 32'd0);

        // Byte-lane write
        wb_write(BASE + 32'h20, 4'b0010, 32'hFFFF_FFFF);
        wb_read(BASE + 32'h20, rd);
        check32("din0_sel", rd, 32'h0000_FF00);
        check32("core_din_sel", core_din[31:0], 32'h0000_FF00);

        // Timeout: ready immediately, done never comes; WAIT lasts exactly 16 cycles
        core_ready = 1'b1;
        wb_write(BASE + 32'h00, 4'h1, 32'h1);
        check1("to_start_in_req", core_start, 1'b1);
        repeat (15) @(posedge clk);
        wb_read(BASE + 32'h04, rd);
        check32("to_busy_at_15", rd, 32'h1);
        wb_read(BASE + 32'h04, rd);
        check32("to_status", rd, 32'h8);
        wb_read(BASE + 32'h30, rd);
        check32("to_dout0", rd, 32'h0);
        core_ready = 1'b0;
        wb_write(BASE + 32'h00, 4'h1, 32'h2);
        wb_read(BASE + 32'h04, rd);
        check32("to_cleared", rd, 32'h0);

        // Main operation
        wb_write(BASE + 32'h10, 4'hF, 32'hCCDD_EEFF);
        wb_write(BASE + 32'h14, 4'hF, 32'h8899_AABB);
        wb_write(BASE + 32'h18, 4'hF, 32'h4455_6677);
        wb_write(BASE + 32'h1C, 4'hF, 32'h0011_2233);
        wb_write(BASE + 32'h20, 4'hF, 32'h89AB_CDEF);
        wb_write(BASE + 32'h24, 4'hF, 32'h0123_4567);
        wb_write(BASE + 32'h28, 4'hF, 32'h89AB_CDEF);
        wb_write(BASE + 32'h2C, 4'hF, 32'h0123_4567);
        check128("core_key", core_key, KEY_V);
        check128("core_din", core_din, DIN_V);
        wb_read(BASE + 32'h14, rd);
        check32("key1_read", rd, 32'h8899_AABB);
        wb_write(BASE + 32'h00, 4'h1, 32'h1);
        check1("start_high", core_start, 1'b1);
        wb_read(BASE + 32'h04, rd);
        check32("status_busy", rd, 32'h1);
        check1("start_held", core_start, 1'b1);
        @(negedge clk) core_ready = 1'b1;
        @(posedge clk); #1;
        check1("start_dropped", core_start, 1'b0);
        @(negedge clk);
        core_ready = 1'b0;
        core_done  = 1'b1;
        core_dout  = {4{32'hA5A5_A5A5}};
        @(negedge clk);
        core_done = 1'b0;
        core_dout = '0;
        check1("irq_done", irq, exp_irq);
        for (int w = 0; w < 4; w++) begin
            wb_read(BASE + 32'h30 + 32'(4 * w), rd);
            check32("dout_word", rd, 32'hA5A5_A5A5);
        end
        wb_read(BASE + 32'h04, rd);
        check32("status_done", rd, 32'h2);

        // done outside WAIT is ignored
        @(negedge clk);
        core_done = 1'b1;
        core_dout = {128{1'b1}};
        @(negedge clk);
        core_done = 1'b0;
        core_dout = '0;
        wb_read(BASE + 32'h30, rd);
        check32("done_ignored_idle", rd, 32'hA5A5_A5A5);
        wb_read(BASE + 32'h08, rd);
        check32("unmapped_zero", rd, 32'h0);
        wb_write(BASE + 32'h00, 4'h1, 32'h2);
        wb_read(BASE + 32'h04, rd);
        check32("status_clear", rd, 32'h0);
        check1("irq_cleared", irq, 1'b0);

        // Write while busy sets err; done coinciding with clear keeps done
        core_ready = 1'b1;
        wb_write(BASE + 32'h00, 4'h1, 32'h1);
        wb_write(BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
        core_ready = 1'b0;
        wb_read(BASE + 32'h04, rd);
        check32("status_busy_err", rd, 32'h5);
        @(posedge clk);
        @(negedge clk);
        core_done = 1'b1;
        core_dout = 128'hCAFEF00D_CAFEF00D_CAFEF00D_1234_5678;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'h1; wdat = 32'h2;
        @(posedge clk); #1;
        check1("clear_ack", ack, 1'b1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        core_done = 1'b0;
        core_dout = '0;
        wb_read(BASE + 32'h04, rd);
        check32("done_beats_clear", rd, 32'h2);
        wb_read(BASE + 32'h10, rd);
        check32("key0_unchanged", rd, 32'hCCDD_EEFF);
        wb_read(BASE + 32'h30, rd);
        check32("dout0_new", rd, 32'h1234_5678);
        wb_write(BASE + 32'h00, 4'h1, 32'h2);
        wb_read(BASE + 32'h04, rd);
        check32("err_cleared", rd, 32'h0);

        // Reset asserted during WAIT while an ack is on the bus
        core_ready = 1'b1;
        wb_write(BASE + 32'h00, 4'h1, 32'h1);
        core_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
        @(posedge clk); #1;
        check32("pre_rst_dat", dat_o, 32'hCCDD_EEFF);
        rst_n = 1'b0;
        #1;
        check1("wait_rst_ack", ack, 1'b0);
        check32("wait_rst_dat", dat_o, 32'h0);
        check1("wait_rst_start", core_start, 1'b0);
        check1("wait_rst_irq", irq, 1'b0);
        check128("wait_rst_key", core_key, 128'h0);
        check128("wait_rst_din", core_din, 128'h0);
        n_ack = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
        end
        check32("rst_pending_noack", 32'(n_ack), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        wb_read(BASE + 32'h04, rd);
        check32("post_rst_status", rd, 32'h0);
        wb_read(BASE + 32'h30, rd);
        check32("post_rst_dout0", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
